// File: rtl/vga_pkg.sv
// Shared VGA constants and sprite-coordinate helpers.
// Optional macro SPRITE_WRAP_EN: coordinates wrap at the screen edges instead of saturating.
package vga_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SPRITE_W = 50;
  localparam int unsigned SPRITE_H = 50;
  localparam int unsigned X_MAX    = SCREEN_W - SPRITE_W;
  localparam int unsigned Y_MAX    = SCREEN_H - SPRITE_H;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic signed [1:0]  delta_t;

  // -1 / 0 / +1 from a pair of opposing pressed flags; both pressed cancels.
  function automatic delta_t axis_delta(input logic dec, input logic inc);
    delta_t d;
    d = 2'sd0;
    if (dec && !inc) begin
      d = -2'sd1;
    end else if (inc && !dec) begin
      d = 2'sd1;
    end
    return d;
  endfunction

  // One-pixel move on an axis bounded to 0..lim. Bit COORD_W of the 11-bit sum flags a
  // step below zero; the largest legal position plus one cannot reach it.
  function automatic coord_t step_axis(input coord_t pos, input delta_t d, input coord_t lim);
    logic [COORD_W:0] nxt;
    coord_t           res;
    nxt = {1'b0, pos} + {{(COORD_W - 1){d[1]}}, d};
    res = nxt[COORD_W-1:0];
    if (nxt[COORD_W]) begin
`ifdef SPRITE_WRAP_EN
      res = lim;
`else
      res = pos;
`endif
    end else if (nxt[COORD_W-1:0] > lim) begin
`ifdef SPRITE_WRAP_EN
      res = '0;
`else
      res = pos;
`endif
    end
    return res;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debounce counter for one
// active-low button. The debounced level is 1 (released) out of reset.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic            sync_q1, sync_q2;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Synchroniser into the pixel clock domain; resets to released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept the new level on the DEB_CYCLES-th consecutive differing sample.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q2 != level_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_d = sync_q2;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sprite_position_ctrl.sv
// Turns four raw active-low buttons into a bounded sprite top-left coordinate. Moves are
// debounced and rate-limited; the visible coordinate only updates on a vsync falling edge.
// Optional macro SPRITE_WRAP_EN: wrap at the edges instead of saturating.
module sprite_position_ctrl #(
  parameter int unsigned SCREEN_W   = vga_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H   = vga_pkg::SCREEN_H,
  parameter int unsigned SPRITE_W   = vga_pkg::SPRITE_W,
  parameter int unsigned SPRITE_H   = vga_pkg::SPRITE_H,
  parameter int unsigned X_INIT     = 200,
  parameter int unsigned Y_INIT     = 200,
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned STEP_DIV   = 1000000
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  input  logic                        up,
  input  logic                        down,
  input  logic                        left,
  input  logic                        right,
  input  logic                        iVS,
  output logic [vga_pkg::COORD_W-1:0] oX,
  output logic [vga_pkg::COORD_W-1:0] oY,
  output logic                        oMoving
);

  localparam int unsigned CW   = vga_pkg::COORD_W;
  localparam int unsigned XMax = SCREEN_W - SPRITE_W;
  localparam int unsigned YMax = SCREEN_H - SPRITE_H;
  localparam int unsigned TmrW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  // Button index order: 0 up, 1 down, 2 left, 3 right.
  logic [3:0] btn_raw, btn_lvl, pressed;

  logic            any_pressed, step_tick, commit;
  vga_pkg::delta_t dx, dy;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [CW-1:0]   px_q, px_d, py_q, py_d;
  logic            vs_q;

  assign btn_raw = {right, left, down, up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
      .clk    (iVGA_CLK),
      .rst_n  (iRST_n),
      .btn_raw(btn_raw[i]),
      .level  (btn_lvl[i])
    );
  end

  assign pressed = ~btn_lvl;

  // Direction decode, step timer, pending-position update and commit detect.
  always_comb begin
    any_pressed = |pressed;
    dx          = vga_pkg::axis_delta(pressed[2], pressed[3]);
    dy          = vga_pkg::axis_delta(pressed[0], pressed[1]);
    step_tick   = any_pressed && (tmr_q == TmrW'(STEP_DIV - 1));
    tmr_d       = tmr_q + 1'b1;
    if (!any_pressed || step_tick) begin
      tmr_d = '0;
    end
    px_d = px_q;
    py_d = py_q;
    if (step_tick) begin
      px_d = vga_pkg::step_axis(px_q, dx, CW'(XMax));
      py_d = vga_pkg::step_axis(py_q, dy, CW'(YMax));
    end
    commit = vs_q && !iVS;
  end

  // Step timer, pending position and registered vsync.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tmr_q <= '0;
      px_q  <= CW'(X_INIT);
      py_q  <= CW'(Y_INIT);
      vs_q  <= 1'b1;
    end else begin
      tmr_q <= tmr_d;
      px_q  <= px_d;
      py_q  <= py_d;
      vs_q  <= iVS;
    end
  end

  // Outputs: commit loads the pre-step pending position, so a frame never tears.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oX      <= CW'(X_INIT);
      oY      <= CW'(Y_INIT);
      oMoving <= 1'b0;
    end else begin
      if (commit) begin
        oX <= px_q;
        oY <= py_q;
      end
      oMoving <= any_pressed;
    end
  end

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// Bench for sprite_position_ctrl with short debounce and step periods, a free-running
// vsync (falling edge every 100 cycles) and a cycle-level behavioural model.
module tb_sprite_position_ctrl;

  localparam int DEB       = 3;
  localparam int DIV       = 4;
  localparam int XMAX      = 590;
  localparam int YMAX      = 430;
  localparam int XI        = 200;
  localparam int YI        = 200;
  localparam int VS_PERIOD = 100;

`ifdef SPRITE_WRAP_EN
  localparam logic [9:0] EXP_LEFT = 10'd588;
  localparam logic [9:0] EXP_DOWN = 10'd1;
`else
  localparam logic [9:0] EXP_LEFT = 10'd0;
  localparam logic [9:0] EXP_DOWN = 10'd430;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
  logic       vs_auto = 1'b1, vs_gen = 1'b1, vs_man = 1'b1;
  logic       ivs;
  logic [9:0] ox, oy;
  logic       moving;

  int n_checks = 0;
  int n_fail   = 0;
  int vs_cnt   = 0;

  assign ivs = vs_auto ? vs_gen : vs_man;

  sprite_position_ctrl #(
    .X_INIT    (XI),
    .Y_INIT    (YI),
    .DEB_CYCLES(DEB),
    .STEP_DIV  (DIV)
  ) dut (
    .iVGA_CLK(clk),
    .iRST_n  (rst_n),
    .up      (up),
    .down    (down),
    .left    (left),
    .right   (right),
    .iVS     (ivs),
    .oX      (ox),
    .oY      (oy),
    .oMoving (moving)
  );

  always #5 clk = ~clk;

  // Free-running vsync: low for 2 cycles out of every VS_PERIOD.
  initial begin
    forever begin
      @(negedge clk);
      vs_cnt = (vs_cnt + 1) % VS_PERIOD;
      vs_gen = (vs_cnt >= 2);
    end
  end

  // ---------------- behavioural reference model ----------------
  logic [3:0] m_d1, m_d2, m_lvl;
  int         m_run [4];
  int         m_held;
  int         m_px, m_py;
  logic [9:0] m_ox, m_oy;
  logic       m_moving, m_vs_prev, m_tick, m_commit;
  int         m_tick_cnt = 0;

  always @(posedge clk or negedge rst_n) begin : model_blk
    logic [3:0] raw, pr, nlvl;
    int         nrun [4];
    int         dx, dy, nx, ny;
    logic       anyp, tick, cmt;
    if (!rst_n) begin
      m_d1      <= 4'hF;
      m_d2      <= 4'hF;
      m_lvl     <= 4'hF;
      for (int b = 0; b < 4; b++) m_run[b] <= 0;
      m_held    <= 0;
      m_px      <= XI;
      m_py      <= YI;
      m_ox      <= 10'(XI);
      m_oy      <= 10'(YI);
      m_moving  <= 1'b0;
      m_vs_prev <= 1'b1;
      m_tick    <= 1'b0;
      m_commit  <= 1'b0;
    end else begin
      raw  = {right, left, down, up};
      pr   = ~m_lvl;
      anyp = |pr;
      // Level flips once DEB consecutive synchronised samples disagree with it.
      for (int b = 0; b < 4; b++) begin
        nlvl[b] = m_lvl[b];
        nrun[b] = 0;
        if (m_d2[b] != m_lvl[b]) begin
          if (m_run[b] + 1 == DEB) nlvl[b] = m_d2[b];
          else                     nrun[b] = m_run[b] + 1;
        end
      end
      dx   = (pr[2] == pr[3]) ? 0 : (pr[2] ? -1 : 1);
      dy   = (pr[0] == pr[1]) ? 0 : (pr[0] ? -1 : 1);
      tick = anyp && ((m_held % DIV) == DIV - 1);
      nx   = m_px;
      ny   = m_py;
      if (tick) begin
        nx = m_px + dx;
        ny = m_py + dy;
`ifdef SPRITE_WRAP_EN
        if (nx < 0) nx = XMAX; else if (nx > XMAX) nx = 0;
        if (ny < 0) ny = YMAX; else if (ny > YMAX) ny = 0;
`else
        if (nx < 0 || nx > XMAX) nx = m_px;
        if (ny < 0 || ny > YMAX) ny = m_py;
`endif
      end
      cmt = m_vs_prev && !ivs;
      m_d2  <= m_d1;
      m_d1  <= raw;
      m_lvl <= nlvl;
      for (int b = 0; b < 4; b++) m_run[b] <= nrun[b];
      m_held <= anyp ? m_held + 1 : 0;
      m_px   <= nx;
      m_py   <= ny;
      if (cmt) begin
        m_ox <= 10'(m_px);
        m_oy <= 10'(m_py);
      end
      m_vs_prev <= ivs;
      m_moving  <= anyp;
      m_tick    <= tick;
      m_commit  <= cmt;
      if (tick) m_tick_cnt <= m_tick_cnt + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    vs_auto = 1'b1;
    {right, left, down, up} = 4'hF;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the negedge following a model step tick.
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_tick) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns at the negedge following a commit edge.
  task automatic wait_commit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_commit) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit ok;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (ox !== 10'd200 || oy !== 10'd200 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: got x=%0d y=%0d mv=%b want 200 200 0", ox, oy, moving);
    end
    right = 1'b0;
    repeat (150) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ox !== 10'd200) begin
      n_fail++;
      $display("FAIL reset_async_x: got %0d want 200", ox);
    end
    n_checks++;
    if (oy !== 10'd200) begin
      n_fail++;
      $display("FAIL reset_async_y: got %0d want 200", oy);
    end
    n_checks++;
    if (moving !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_moving: got %b want 0", moving);
    end
    right = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    wait_commit(ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_commit_timeout: got %b want 1", ok);
    end
    n_checks++;
    if (ox !== 10'd200 || oy !== 10'd200 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got x=%0d y=%0d mv=%b want 200 200 0", ox, oy, moving);
    end
  endtask

  task automatic test_bounce();
    bit         ok, seen;
    int         t0, lat;
    logic [9:0] exp_x;
    do_reset();
    seen = 1'b0;
    repeat (10) begin
      right = 1'b0;
      repeat (2) begin @(negedge clk); seen |= moving; end
      right = 1'b1;
      repeat (2) begin @(negedge clk); seen |= moving; end
    end
    n_checks++;
    if (seen !== 1'b0 || ox !== 10'd200) begin
      n_fail++;
      $display("FAIL bounce_reject: got moving_seen=%b x=%0d want 0 200", seen, ox);
    end
    t0    = m_tick_cnt;
    right = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (moving === 1'b1 && lat < 0) lat = i;
    end
    n_checks++;
    if (lat < 1 || lat > 6) begin
      n_fail++;
      $display("FAIL bounce_moving_latency: got %0d cycles want 1..6", lat);
    end
    right = 1'b1;
    repeat (12) @(negedge clk);
    wait_commit(ok);
    exp_x = 10'(XI + m_tick_cnt - t0);
    n_checks++;
    if (ok !== 1'b1 || ox !== exp_x) begin
      n_fail++;
      $display("FAIL bounce_steps: got x=%0d (commit=%b) want %0d", ox, ok, exp_x);
    end
  endtask

  task automatic test_opposing_diagonal();
    bit ok1, ok2, ok3;
    do_reset();
    {right, down, up} = 3'b000;
    wait_tick(ok1);
    wait_tick(ok2);
    {right, down, up} = 3'b111;
    repeat (10) @(negedge clk);
    wait_commit(ok3);
    n_checks++;
    if ({ok1, ok2, ok3} !== 3'b111) begin
      n_fail++;
      $display("FAIL opp_timeout: got %b want 111", {ok1, ok2, ok3});
    end
    n_checks++;
    if (ox !== 10'd203 || oy !== 10'd200) begin
      n_fail++;
      $display("FAIL opp_diag: got x=%0d y=%0d want 203 200", ox, oy);
    end
    up = 1'b0;
    wait_tick(ok1);
    up = 1'b1;
    repeat (10) @(negedge clk);
    wait_commit(ok2);
    n_checks++;
    if (ok1 !== 1'b1 || ok2 !== 1'b1 || ox !== 10'd203 || oy !== 10'd198) begin
      n_fail++;
      $display("FAIL up_only: got x=%0d y=%0d want 203 198", ox, oy);
    end
  endtask

  task automatic test_clamp();
    bit ok, ok2;
    do_reset();
    left = 1'b0;
    for (int i = 0; i < 250; i++) begin
      wait_tick(ok);
      if (!ok || m_px == 2) break;
    end
    // Four more ticks, then one more lands while the release is being debounced.
    repeat (4) wait_tick(ok);
    left = 1'b1;
    repeat (10) @(negedge clk);
    wait_commit(ok2);
    n_checks++;
    if (ok !== 1'b1 || ok2 !== 1'b1 || ox !== EXP_LEFT || oy !== 10'd200) begin
      n_fail++;
      $display("FAIL left_bound: got x=%0d y=%0d want %0d 200", ox, oy, EXP_LEFT);
    end
    down = 1'b0;
    for (int i = 0; i < 250; i++) begin
      wait_tick(ok);
      if (!ok || m_py == 429) break;
    end
    repeat (2) wait_tick(ok);
    down = 1'b1;
    repeat (10) @(negedge clk);
    wait_commit(ok2);
    n_checks++;
    if (ok !== 1'b1 || ok2 !== 1'b1 || oy !== EXP_DOWN || ox !== EXP_LEFT) begin
      n_fail++;
      $display("FAIL bottom_bound: got x=%0d y=%0d want %0d %0d", ox, oy, EXP_LEFT, EXP_DOWN);
    end
  endtask

  task automatic test_tear_free();
    bit         ok, changed;
    int         p, t0;
    logic [9:0] exp_x;
    do_reset();
    vs_auto = 1'b0;
    vs_man  = 1'b1;
    right   = 1'b0;
    wait_tick(ok);
    p  = m_px;
    t0 = m_tick_cnt;
    repeat (3) @(negedge clk);
    vs_man = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ok !== 1'b1 || ox !== 10'(p)) begin
      n_fail++;
      $display("FAIL tear_coincident: got x=%0d want %0d", ox, p);
    end
    vs_man  = 1'b1;
    right   = 1'b1;
    changed = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (ox !== 10'(p)) changed = 1'b1;
    end
    n_checks++;
    if (changed !== 1'b0) begin
      n_fail++;
      $display("FAIL tear_stable: got change=%b want 0", changed);
    end
    vs_man = 1'b0;
    @(negedge clk);
    exp_x = 10'(p + m_tick_cnt - t0);
    n_checks++;
    if (ox !== exp_x) begin
      n_fail++;
      $display("FAIL tear_next_edge: got x=%0d want %0d", ox, exp_x);
    end
    vs_man  = 1'b1;
    vs_auto = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (ox !== m_ox) begin
        n_fail++;
        $display("FAIL rand_x @%0d: got %0d want %0d", cyc, ox, m_ox);
      end
      n_checks++;
      if (oy !== m_oy) begin
        n_fail++;
        $display("FAIL rand_y @%0d: got %0d want %0d", cyc, oy, m_oy);
      end
      n_checks++;
      if (moving !== m_moving) begin
        n_fail++;
        $display("FAIL rand_moving @%0d: got %b want %b", cyc, moving, m_moving);
      end
      if ($urandom_range(15) == 0) {right, left, down, up} = 4'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_opposing_diagonal();
    test_clamp();
    test_tear_free();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
